tone_detector: RTL and testbench
================================

TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 SHALL have parameter CNT_BITS, default 24: width of the period counter and the period output.
REQ-002 SHALL have parameter AVG_LOG2, default 2: the block averages 2^AVG_LOG2 periods per result.
REQ-003 SHALL have parameter TIMEOUT, default 1048576: number of cycles without a rising edge before loss of signal.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in, input, 1 bit: asynchronous square-wave tone, as produced by the sound generator.
REQ-007 SHALL have port period, output, CNT_BITS bits: averaged period of in, in clock cycles.
REQ-008 SHALL have port period_valid, output, 1 bit: one-cycle pulse marking a new period value.
REQ-009 SHALL have port locked, output, 1 bit: high while results are being produced.
REQ-010 SHALL have port no_signal, output, 1 bit: high when no tone is detected.

Function
REQ-011 SHALL pass in through a two-flop synchronizer (s1, s2) and register s2 as prev; rise = s2 & ~prev.
REQ-012 SHALL implement FSM states IDLE and MEASURE.
REQ-013 In IDLE, SHALL hold cnt=0; on rise, SHALL go to MEASURE with cnt=1, acc=0, nsamp=0, no_signal=0.
REQ-014 In MEASURE without rise, SHALL increment cnt, saturating at all-ones with no wrap.
REQ-015 In MEASURE on rise, SHALL add cnt to acc (CNT_BITS+AVG_LOG2 bits), increment nsamp, and set cnt=1.
REQ-016 When this addition brings nsamp to 2^AVG_LOG2, SHALL on the next edge register period=(acc+cnt)>>AVG_LOG2 (truncating), pulse period_valid for 1 cycle, set locked=1, and clear acc and nsamp.
REQ-017 Latency: an in rising edge sampled at clock edge k SHALL produce period_valid high during the cycle after edge k+2.
REQ-018 In MEASURE, when cnt reaches TIMEOUT with no rise that cycle, SHALL go to IDLE with locked=0, no_signal=1, period=0, acc=0, nsamp=0.
REQ-019 Timeout and rise in the same cycle: rise SHALL win, and the timeout is not taken.
REQ-020 period SHALL hold its value between period_valid pulses.
REQ-021 Falling edges SHALL be ignored; duty cycle SHALL NOT affect the result.

Reset
REQ-022 Reset value of outputs SHALL be period=0, period_valid=0, locked=0, no_signal=1.
REQ-023 Reset SHALL set FSM=IDLE, cnt=0, acc=0, nsamp=0, and s1=s2=prev=0.
REQ-024 Reset asserted mid-measurement SHALL discard partial accumulation, and no period_valid SHALL follow it.

Configuration
REQ-025 With TONE_DETECTOR_GLITCH_FILTER_EN defined, SHALL insert a 3-sample majority filter after s2, adding exactly 2 cycles to REQ-017 latency and rejecting pulses of 1 cycle.
REQ-026 Without TONE_DETECTOR_GLITCH_FILTER_EN, s2 SHALL feed edge detection directly, and single-cycle pulses SHALL count as edges.

Verification
REQ-027 AVG_LOG2=2, in = square wave, period 100 cycles, 50% duty -> after the 5th rising edge: period=100, one period_valid pulse, locked=1, no_signal=0.
REQ-028 Rising edges spaced 10,11,10,11 cycles -> period=10 (42>>2 truncation).
REQ-029 TIMEOUT=1000, in stops low after lock -> 1000 cycles after last counted edge: locked=0, no_signal=1, period=0.
REQ-030 Reset pulse after 2 of 4 periods, tone continues at 50 cycles -> first period_valid after 5 new rising edges, period=50.
REQ-031 Period-40 tone plus one 1-cycle high glitch mid-low-phase -> with macro: period=40; without macro: the result differs from 40.
REQ-032 in held high for 2^CNT_BITS+10 cycles with TIMEOUT above the counter range -> cnt saturates at all-ones, with no wrap to a small value.

Source files
------------

// File: rtl/tone_detector.sv
// Tone period detector: measures the spacing of rising edges on an asynchronous
// square wave and reports the average over 2^AVG_LOG2 periods. Reports loss of
// signal when no rising edge arrives for TIMEOUT cycles.
// Optional build macro: TONE_DETECTOR_GLITCH_FILTER_EN inserts a 3-sample
// majority filter ahead of edge detection (two extra cycles of latency,
// single-cycle pulses rejected).
module tone_detector #(
  parameter int unsigned CNT_BITS = 24,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 1048576
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in,
  output logic [CNT_BITS-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                no_signal
);

  localparam int unsigned ACC_W = CNT_BITS + AVG_LOG2;
  localparam int unsigned NS_W  = AVG_LOG2 + 1;
  localparam logic [NS_W-1:0]     NS_LAST = NS_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  logic r_s1, r_s2, r_prev;
  logic w_edge_src, w_rise, w_timeout;

  state_t              r_state,  w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt,    w_cnt_nxt;
  logic [ACC_W-1:0]    r_acc,    w_acc_nxt;
  logic [NS_W-1:0]     r_nsamp,  w_nsamp_nxt;
  logic [CNT_BITS-1:0] r_period, w_period_nxt;
  logic                r_valid,  w_valid_nxt;
  logic                r_locked, w_locked_nxt;
  logic                r_nosig,  w_nosig_nxt;
  logic [ACC_W-1:0]    w_sum;

  // Two-flop synchronizer for the asynchronous tone input
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
    end
  end

`ifdef TONE_DETECTOR_GLITCH_FILTER_EN
  logic r_d1, r_d2, r_filt;

  // Registered 3-sample majority vote; a one-cycle pulse never wins the vote
  always_ff @(posedge clock) begin
    if (reset) begin
      r_d1   <= 1'b0;
      r_d2   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_d1   <= r_s2;
      r_d2   <= r_d1;
      r_filt <= (r_s2 & r_d1) | (r_s2 & r_d2) | (r_d1 & r_d2);
    end
  end

  assign w_edge_src = r_filt;
`else
  assign w_edge_src = r_s2;
`endif

  // Previous level for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= w_edge_src;
  end

  assign w_rise    = w_edge_src & ~r_prev;
  assign w_timeout = (64'(r_cnt) >= 64'(TIMEOUT));
  assign w_sum     = r_acc + ACC_W'(r_cnt);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_nsamp  <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_nosig  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_nsamp  <= w_nsamp_nxt;
      r_period <= w_period_nxt;
      r_valid  <= w_valid_nxt;
      r_locked <= w_locked_nxt;
      r_nosig  <= w_nosig_nxt;
    end
  end

  // Next state: count cycles between rises, average every 2^AVG_LOG2 periods,
  // fall back to IDLE on timeout (a rise in the same cycle takes priority)
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_nsamp_nxt  = r_nsamp;
    w_period_nxt = r_period;
    w_valid_nxt  = 1'b0;
    w_locked_nxt = r_locked;
    w_nosig_nxt  = r_nosig;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = CNT_BITS'(1);
          w_acc_nxt   = '0;
          w_nsamp_nxt = '0;
          w_nosig_nxt = 1'b0;
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          w_cnt_nxt = CNT_BITS'(1);
          if (r_nsamp == NS_LAST) begin
            w_period_nxt = CNT_BITS'(w_sum >> AVG_LOG2);
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
            w_acc_nxt    = '0;
            w_nsamp_nxt  = '0;
          end else begin
            w_acc_nxt   = w_sum;
            w_nsamp_nxt = r_nsamp + NS_W'(1);
          end
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_acc_nxt    = '0;
          w_nsamp_nxt  = '0;
          w_period_nxt = '0;
          w_locked_nxt = 1'b0;
          w_nosig_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_BITS'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign no_signal    = r_nosig;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: random and directed tones on a 24-bit instance,
// compared every cycle against an edge-list reference model; a 6-bit instance
// covers counter saturation.
module tb_tone_detector;

  localparam int A_CNT  = 24;
  localparam int A_AVG  = 2;
  localparam int A_TMO  = 1000;
  localparam int A_MAXC = (1 << A_CNT) - 1;
  localparam int HN     = 65536;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset_a = 1'b1, in_a = 1'b0;
  logic [A_CNT-1:0] period_a;
  logic             valid_a, locked_a, nosig_a;

  logic       reset_b = 1'b1, in_b = 1'b0;
  logic [5:0] period_b;
  logic       valid_b, locked_b, nosig_b;

  tone_detector #(.CNT_BITS(A_CNT), .AVG_LOG2(A_AVG), .TIMEOUT(A_TMO)) dut_a (
    .clock(clock), .reset(reset_a), .in(in_a), .period(period_a),
    .period_valid(valid_a), .locked(locked_a), .no_signal(nosig_a));

  tone_detector #(.CNT_BITS(6), .AVG_LOG2(2), .TIMEOUT(1000)) dut_b (
    .clock(clock), .reset(reset_b), .in(in_b), .period(period_b),
    .period_valid(valid_b), .locked(locked_b), .no_signal(nosig_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: input history per clock edge, rises derived from it
  logic hist [HN];
  int   e = -1;
  bit   m_active = 0;
  int   m_last = 0;
  int   m_q[$];
  int   m_period = 0;
  bit   m_valid = 0, m_locked = 0, m_nosig = 1;
  int   nvalid = 0;

  function automatic bit h(input int i);
    if (i < 0) return 1'b0;
    return hist[i % HN];
  endfunction

  function automatic bit f(input int i);
    int s;
    s = int'(h(i)) + int'(h(i - 1)) + int'(h(i - 2));
    return s >= 2;
  endfunction

  function automatic bit rise_at(input int k);
`ifdef TONE_DETECTOR_GLITCH_FILTER_EN
    return f(k - 3) & ~f(k - 4);
`else
    return h(k - 2) & ~h(k - 3);
`endif
  endfunction

  task automatic model_edge(input logic lvl, input logic rst);
    bit r;
    int s, sum;
    e++;
    hist[e % HN] = rst ? 1'b0 : lvl;
    m_valid = 0;
    if (rst) begin
      for (int i = e - 6; i <= e; i++) if (i >= 0) hist[i % HN] = 1'b0;
      m_active = 0; m_q.delete(); m_period = 0; m_locked = 0; m_nosig = 1;
      return;
    end
    r = rise_at(e);
    if (!m_active) begin
      if (r) begin
        m_active = 1; m_last = e; m_q.delete(); m_nosig = 0;
      end
    end else if (r) begin
      s = e - m_last;
      if (s > A_MAXC) s = A_MAXC;
      m_q.push_back(s);
      m_last = e;
      if (m_q.size() == (1 << A_AVG)) begin
        sum = 0;
        foreach (m_q[i]) sum += m_q[i];
        m_period = sum >> A_AVG;
        m_valid = 1; m_locked = 1;
        m_q.delete();
      end
    end else if ((e - m_last) >= A_TMO && A_TMO <= A_MAXC) begin
      m_active = 0; m_locked = 0; m_nosig = 1; m_period = 0; m_q.delete();
    end
  endtask

  // One clock: drive, let the edge happen, compare on the falling edge
  task automatic step(input logic lvl, input logic rst);
    in_a = lvl; reset_a = rst;
    @(posedge clock);
    model_edge(lvl, rst);
    @(negedge clock);
    chk("valid",  32'(valid_a),  32'(m_valid));
    chk("period", 32'(period_a), 32'(m_period));
    chk("locked", 32'(locked_a), 32'(m_locked));
    chk("nosig",  32'(nosig_a),  32'(m_nosig));
    if (valid_a === 1'b1) nvalid++;
  endtask

  task automatic hold(input logic lvl, input int n);
    repeat (n) step(lvl, 1'b0);
  endtask

  task automatic tone(input int p, input int hi, input int n);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, p - hi);
    end
  endtask

  task automatic rst_pulse();
    step(1'b0, 1'b1);
    nvalid = 0;
  endtask

  // Saturation instance: 74-cycle high (> 2^6) then three 20-cycle periods
  int  nvalid_b = 0;
  bit  b_done = 0;
  always @(negedge clock) if (!reset_b && valid_b === 1'b1) nvalid_b++;

  initial begin
    repeat (3) @(negedge clock);
    reset_b = 1'b0;
    repeat (5) @(negedge clock);
    in_b = 1'b1; repeat (74) @(negedge clock);
    in_b = 1'b0; repeat (5) @(negedge clock);
    repeat (3) begin
      in_b = 1'b1; repeat (10) @(negedge clock);
      in_b = 1'b0; repeat (10) @(negedge clock);
    end
    in_b = 1'b1; repeat (10) @(negedge clock);
    in_b = 1'b0; repeat (10) @(negedge clock);
    b_done = 1;
  end

  initial begin
    // reset state
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    chk("rst_period", 32'(period_a), 0);
    chk("rst_valid",  32'(valid_a),  0);
    chk("rst_locked", 32'(locked_a), 0);
    chk("rst_nosig",  32'(nosig_a),  1);
    hold(1'b0, 5);
    nvalid = 0;

    // 100-cycle square wave: one result after the 5th rise
    tone(100, 50, 5);
    chk("sq100_period", 32'(period_a), 100);
    chk("sq100_locked", 32'(locked_a), 1);
    chk("sq100_nosig",  32'(nosig_a),  0);
    chk("sq100_nvalid", 32'(nvalid),   1);

    // spacing 10,11,10,11 -> 42>>2 = 10
    rst_pulse(); hold(1'b0, 4);
    tone(10, 5, 1); tone(11, 5, 1); tone(10, 5, 1); tone(11, 5, 1);
    hold(1'b1, 6);
    chk("trunc_period", 32'(period_a), 10);
    hold(1'b0, 5);

    // period-40 tone with a one-cycle glitch in a low phase
    rst_pulse(); hold(1'b0, 4);
    tone(40, 20, 2);
    hold(1'b1, 20); hold(1'b0, 9); hold(1'b1, 1); hold(1'b0, 10);
    tone(40, 20, 1);
    hold(1'b1, 20); hold(1'b0, 10);
`ifdef TONE_DETECTOR_GLITCH_FILTER_EN
    chk("glitch_period", 32'(period_a), 40);
`else
    chk("glitch_differs", 32'(period_a != 40), 1);
`endif

    // loss of signal after lock
    hold(1'b0, 1100);
    chk("tmo_locked", 32'(locked_a), 0);
    chk("tmo_nosig",  32'(nosig_a),  1);
    chk("tmo_period", 32'(period_a), 0);

    // rise arriving exactly at the timeout count wins; one later does not
    rst_pulse(); hold(1'b0, 3);
    hold(1'b1, 2); hold(1'b0, 998); hold(1'b1, 2); hold(1'b0, 5);
    chk("tmo_eq_nosig", 32'(nosig_a), 0);
    hold(1'b0, 1010);
    chk("tmo_gt_nosig", 32'(nosig_a), 1);

    // reset mid-measurement discards partial accumulation
    rst_pulse(); hold(1'b0, 3);
    tone(50, 25, 2); hold(1'b1, 25);
    rst_pulse(); hold(1'b0, 24);
    tone(50, 25, 4);
    chk("midrst_none", 32'(nvalid), 0);
    hold(1'b1, 10);
    chk("midrst_nvalid", 32'(nvalid), 1);
    chk("midrst_period", 32'(period_a), 50);
    hold(1'b0, 15);

    // randomized tones, duty cycles, gaps and resets
    for (int k = 0; k < 40; k++) begin
      int p, hi;
      p  = int'($urandom_range(4, 60));
      hi = int'($urandom_range(1, p - 1));
      tone(p, hi, int'($urandom_range(1, 7)));
      if ($urandom_range(0, 9) == 0) hold(1'b0, int'($urandom_range(990, 1010)));
      if ($urandom_range(0, 14) == 0) rst_pulse();
    end

    // saturation instance results
    chk("sat_done",   32'(b_done),   1);
    chk("sat_period", 32'(period_b), 30);
    chk("sat_nvalid", 32'(nvalid_b), 1);
    chk("sat_locked", 32'(locked_b), 1);
    chk("sat_nosig",  32'(nosig_b),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
